gauss_line_buffer: RTL and testbench
====================================

GAUSS_LINE_BUFFER -- requirements
Module: gauss_line_buffer

Interface
REQ-001 SHALL have parameter IMG_W, default 640, pixels per image line (legal range 4..4096).
REQ-002 SHALL have parameter ADDR_W, default 10, column counter/memory address width; SHALL satisfy 2^ADDR_W >= IMG_W.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sof_i  input  1  start of frame; qualified by pix_valid_i; marks pixel at row 0, column 0.
REQ-006 pix_valid_i  input  1  pix_i valid this cycle.
REQ-007 pix_i  input  8  raster-order pixel.
REQ-008 d1_o  output  8  pixel from row r-2 (top window line).
REQ-009 d2_o  output  8  pixel from row r-1 (middle window line).
REQ-010 d3_o  output  8  pixel from row r (bottom window line, current input).
REQ-011 valid_o  output  1  d1_o/d2_o/d3_o hold a new column-aligned triple.
REQ-012 en_o  output  1  one-cycle pulse with the first valid_o of each output row; drives filter en_i.
REQ-013 err_o  output  1  sticky line-length error flag (see Configuration).

Function
REQ-014 SHALL contain two line memories LA and LB, each IMG_W x 8, one write and one read per accepted pixel.
REQ-015 Accepted pixel = pix_valid_i high at a rising edge; no other cycle SHALL change col, row, memories or FSM state.
REQ-016 Per accepted pixel at column c: read LA[c] and LB[c]; write LB[c] <= old LA[c]; write LA[c] <= pix_i (read-before-write).
REQ-017 col SHALL count 0..IMG_W-1 and wrap to 0 after IMG_W-1; row SHALL increment on wrap and saturate at 2.
REQ-018 FSM states: IDLE, FILL0 (row 0), FILL1 (row 1), STREAM (row >= 2).
REQ-019 IDLE -> FILL0 on accepted pixel with sof_i=1; accepted pixels in IDLE with sof_i=0 SHALL be discarded.
REQ-020 FILL0 -> FILL1 on column wrap; FILL1 -> STREAM on column wrap; STREAM persists until next sof_i.
REQ-021 Accepted pixel with sof_i=1 in any state SHALL force col=0, row=0, state FILL0, that pixel being column 0; memories SHALL NOT be cleared.
REQ-022 In STREAM, one cycle after an accepted pixel: d1_o=old LB[c], d2_o=old LA[c], d3_o=pix_i, valid_o=1 (latency 1 clk).
REQ-023 valid_o SHALL be 0 in IDLE, FILL0, FILL1, and in any cycle not following an accepted STREAM pixel; d*_o SHALL hold last values when valid_o=0.
REQ-024 en_o SHALL pulse high coincident with valid_o for column 0 of every STREAM row, else 0.
REQ-025 Gaps in pix_valid_i (any length, any column) SHALL NOT corrupt alignment.

Reset
REQ-026 On rst_n low: state=IDLE, col=0, row=0, d1_o=d2_o=d3_o=0, valid_o=0, en_o=0, err_o=0, immediately and asynchronously.
REQ-027 Memory contents SHALL NOT be reset; reset mid-frame SHALL require a new sof_i before output resumes.

Configuration
REQ-028 Macro GAUSS_LB_ERR_DET_EN: when defined, err_o SHALL set (sticky until reset) on an accepted sof_i pixel while col != 0 and state != IDLE (truncated line).
REQ-029 Without GAUSS_LB_ERR_DET_EN, err_o SHALL be constant 0 and no detection logic built; all other behaviour identical.

Verification
REQ-030 IMG_W=4, frame of rows 0..3 with pix = 16*row+col, continuous valid -> first valid_o is the cycle after row 2 col 0 accepted: d1_o=0x00, d2_o=0x10, d3_o=0x20, en_o=1; 8 valid_o total.
REQ-031 Same frame with pix_valid_i low every other cycle -> identical output triple sequence, valid_o never on two consecutive cycles.
REQ-032 Pixels before any sof_i (values 0xAA) -> valid_o stays 0, state IDLE; following frame per REQ-030 unaffected.
REQ-033 sof_i at row 2 col 2 -> next 2*IMG_W accepted pixels produce valid_o=0; err_o=1 only with GAUSS_LB_ERR_DET_EN defined.
REQ-034 rst_n low mid-STREAM -> all outputs 0 asynchronously; after release, valid_o=0 until new sof_i plus two full rows.

Source files
------------

// File: rtl/gauss_line_buffer.sv
// -----------------------------------------------------------------------------
// gauss_line_buffer
//
// Three-line window generator for a 3x3 Gaussian filter. Two line memories
// (LA = previous row, LB = row before that) are rotated on every accepted
// pixel, so each output beat presents one column of the vertical window:
// d1_o = row r-2, d2_o = row r-1, d3_o = row r (the pixel just accepted).
//
// Optional feature (macro GAUSS_LB_ERR_DET_EN): a sticky truncated-line
// detector drives err_o. Without the macro err_o is tied to 0.
//
// Parameters
//   IMG_W   pixels per line (4..4096)
//   ADDR_W  column counter / memory address width, 2**ADDR_W >= IMG_W
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   sof_i        start of frame, qualified by pix_valid_i (row 0, column 0)
//   pix_valid_i  pix_i valid this cycle
//   pix_i        8-bit raster-order pixel
//   d1_o/d2_o/d3_o  column-aligned window triple (top/middle/bottom)
//   valid_o      new triple present (one cycle after an accepted STREAM pixel)
//   en_o         pulse with the first valid_o of each output row
//   err_o        sticky truncated-line flag (0 unless GAUSS_LB_ERR_DET_EN)
// -----------------------------------------------------------------------------
module gauss_line_buffer #(
   parameter int unsigned IMG_W  = 640,
   parameter int unsigned ADDR_W = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sof_i,
   input  logic       pix_valid_i,
   input  logic [7:0] pix_i,
   output logic [7:0] d1_o,
   output logic [7:0] d2_o,
   output logic [7:0] d3_o,
   output logic       valid_o,
   output logic       en_o,
   output logic       err_o
);

   typedef enum logic [1:0] {StIdle, StFill0, StFill1, StStream} state_e;

   localparam logic [ADDR_W-1:0] LastCol = ADDR_W'(IMG_W - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] col_q, col_d;
   logic [1:0]        row_q, row_d;

   // Effective position of the pixel being accepted: an sof_i pixel is
   // always column 0 of row 0 in FILL0, whatever the counters held.
   state_e            st_eff;
   logic [ADDR_W-1:0] col_eff;
   logic [1:0]        row_eff;
   logic              take;
   logic              wrap;
   logic              stream_pix;

   logic [7:0] la_mem [IMG_W];
   logic [7:0] lb_mem [IMG_W];

   logic [7:0] d1_q, d2_q, d3_q;
   logic       valid_q, en_q;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      st_eff     = sof_i ? StFill0 : state_q;
      col_eff    = sof_i ? '0 : col_q;
      row_eff    = sof_i ? 2'd0 : row_q;
      // Pixels seen in IDLE without sof_i are dropped entirely.
      take       = pix_valid_i && (sof_i || (state_q != StIdle));
      wrap       = (col_eff == LastCol);
      stream_pix = take && (st_eff == StStream);

      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;

      if (take) begin
         state_d = st_eff;
         if (wrap) begin
            col_d = '0;
            row_d = (row_eff == 2'd2) ? 2'd2 : row_eff + 2'd1;
            unique case (st_eff)
               StFill0: state_d = StFill1;
               StFill1: state_d = StStream;
               default: state_d = st_eff;
            endcase
         end else begin
            col_d = col_eff + ADDR_W'(1);
            row_d = row_eff;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         col_q   <= '0;
         row_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Line memories: not reset. Non-blocking writes give read-before-write, so
   // LB receives the row that LA held before this pixel overwrote it.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (take) begin
         lb_mem[col_eff] <= la_mem[col_eff];
         la_mem[col_eff] <= pix_i;
      end
   end

   // ---------------------------------------------------------------------------
   // Output registers: data holds when no STREAM pixel was accepted.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d1_q    <= 8'd0;
         d2_q    <= 8'd0;
         d3_q    <= 8'd0;
         valid_q <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         valid_q <= stream_pix;
         en_q    <= stream_pix && (col_eff == '0);
         if (stream_pix) begin
            d1_q <= lb_mem[col_eff];
            d2_q <= la_mem[col_eff];
            d3_q <= pix_i;
         end
      end
   end

   assign d1_o    = d1_q;
   assign d2_o    = d2_q;
   assign d3_o    = d3_q;
   assign valid_o = valid_q;
   assign en_o    = en_q;

   // ---------------------------------------------------------------------------
   // Truncated-line detection: a new frame starting mid-line.
   // ---------------------------------------------------------------------------
`ifdef GAUSS_LB_ERR_DET_EN
   logic err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (pix_valid_i && sof_i && (state_q != StIdle) && (col_q != '0)) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gauss_line_buffer.sv
// -----------------------------------------------------------------------------
// tb_gauss_line_buffer
//
// Scoreboard bench for gauss_line_buffer (IMG_W=4). The reference model keeps
// the last three image rows of the current frame as plain arrays indexed by
// frame row number; every accepted pixel at row >= 2 queues the expected
// window column. A monitor pops and compares whenever valid_o is high.
// -----------------------------------------------------------------------------
module tb_gauss_line_buffer;

   localparam int unsigned IMG_W  = 4;
   localparam int unsigned ADDR_W = 2;

   logic       clk;
   logic       rst_n;
   logic       sof_i;
   logic       pix_valid_i;
   logic [7:0] pix_i;
   logic [7:0] d1_o, d2_o, d3_o;
   logic       valid_o, en_o, err_o;

   gauss_line_buffer #(
      .IMG_W (IMG_W),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sof_i      (sof_i),
      .pix_valid_i(pix_valid_i),
      .pix_i      (pix_i),
      .d1_o       (d1_o),
      .d2_o       (d2_o),
      .d3_o       (d3_o),
      .valid_o    (valid_o),
      .en_o       (en_o),
      .err_o      (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic [7:0] d1;
      logic [7:0] d2;
      logic [7:0] d3;
      int         cyc;
   } exp_t;

   exp_t sbq[$];

   int checks    = 0;
   int errors    = 0;
   int cyc       = 0;
   int obs_count = 0;
   int exp_count = 0;
   int consec    = 0;
   bit gap_mode  = 1'b0;
   bit prev_vld  = 1'b0;

   // Reference model state
   bit         m_active = 1'b0;
   int         m_row    = 0;
   int         m_col    = 0;
   bit         exp_err  = 1'b0;
   logic [7:0] lines [3][IMG_W];

   function automatic void check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endfunction

   function automatic void model_reset();
      m_active = 1'b0;
      m_row    = 0;
      m_col    = 0;
      exp_err  = 1'b0;
      sbq.delete();
   endfunction

   function automatic void model_accept(input bit sof, input logic [7:0] pix, input int at_cyc);
      exp_t e;
      if (sof) begin
`ifdef GAUSS_LB_ERR_DET_EN
         if (m_active && m_col != 0) exp_err = 1'b1;
`endif
         m_active = 1'b1;
         m_row    = 0;
         m_col    = 0;
      end else if (!m_active) begin
         return;
      end
      lines[m_row % 3][m_col] = pix;
      if (m_row >= 2) begin
         e.en  = (m_col == 0);
         e.d1  = lines[(m_row - 2) % 3][m_col];
         e.d2  = lines[(m_row - 1) % 3][m_col];
         e.d3  = pix;
         e.cyc = at_cyc;
         sbq.push_back(e);
         exp_count++;
      end
      m_col++;
      if (m_col == IMG_W) begin
         m_col = 0;
         m_row++;
      end
   endfunction

   // Drive one cycle of input on the falling edge; accepted at the next rise.
   task automatic send(input bit sof, input bit vld, input logic [7:0] pix);
      @(negedge clk);
      sof_i       = sof;
      pix_valid_i = vld;
      pix_i       = pix;
      if (vld) model_accept(sof, pix, cyc + 1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send(1'b0, 1'b0, 8'($urandom));
   endtask

   task automatic frame(input int nrows, input bit gap);
      for (int r = 0; r < nrows; r++) begin
         for (int c = 0; c < IMG_W; c++) begin
            send((r == 0) && (c == 0), 1'b1, 8'(16 * r + c));
            if (gap) idle(1);
         end
      end
   endtask

   task automatic end_phase(input string name, input int obs0, input int exp0);
      idle(3);
      check({name, "_queue_empty"}, sbq.size(), 0);
      check({name, "_valid_count"}, obs_count - obs0, exp_count - exp0);
      check({name, "_err"}, int'(err_o), int'(exp_err));
   endtask

   // Monitor: compare every presented triple against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (valid_o) begin
            obs_count++;
            if (gap_mode && prev_vld) consec++;
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: got valid_o=1 d=%0h/%0h/%0h expected valid_o=0",
                        d1_o, d2_o, d3_o);
            end else begin
               e = sbq.pop_front();
               check("d1", d1_o, e.d1);
               check("d2", d2_o, e.d2);
               check("d3", d3_o, e.d3);
               check("en", en_o, e.en);
               check("latency_cycle", cyc, e.cyc);
            end
         end else if (en_o) begin
            check("en_without_valid", en_o, 0);
         end
         prev_vld = valid_o;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int o0, e0;
      bit vld, sof;
      rst_n       = 1'b0;
      sof_i       = 1'b0;
      pix_valid_i = 1'b0;
      pix_i       = 8'd0;
      #1;
      check("rst_valid", valid_o, 0);
      check("rst_en", en_o, 0);
      check("rst_err", err_o, 0);
      check("rst_d1", d1_o, 0);
      check("rst_d2", d2_o, 0);
      check("rst_d3", d3_o, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Junk before any sof, then the directed frame.
      o0 = obs_count; e0 = exp_count;
      for (int i = 0; i < 6; i++) send(1'b0, 1'b1, 8'hAA);
      frame(4, 1'b0);
      end_phase("frame_cont", o0, e0);
      check("frame_cont_count8", obs_count - o0, 8);

      // Same frame with a bubble after every pixel.
      o0 = obs_count; e0 = exp_count;
      gap_mode = 1'b1;
      consec   = 0;
      frame(4, 1'b1);
      end_phase("frame_gap", o0, e0);
      gap_mode = 1'b0;
      check("frame_gap_count8", obs_count - o0, 8);
      check("frame_gap_no_consecutive", consec, 0);

      // Truncated frame: sof arrives at row 2 column 2.
      o0 = obs_count; e0 = exp_count;
      frame(2, 1'b0);
      send(1'b0, 1'b1, 8'h20);
      send(1'b0, 1'b1, 8'h21);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < IMG_W; c++) send((r == 0) && (c == 0), 1'b1, 8'(8'h80 + 16 * r + c));
      end_phase("trunc", o0, e0);

      // Reset in the middle of STREAM.
      frame(3, 1'b0);
      idle(1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_valid", valid_o, 0);
      check("midrst_en", en_o, 0);
      check("midrst_err", err_o, 0);
      check("midrst_d1", d1_o, 0);
      check("midrst_d2", d2_o, 0);
      check("midrst_d3", d3_o, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      o0 = obs_count; e0 = exp_count;
      for (int i = 0; i < 8; i++) send(1'b0, 1'b1, 8'($urandom));
      frame(4, 1'b0);
      end_phase("after_rst", o0, e0);

      // Randomized traffic with gaps and occasional restarts.
      o0 = obs_count; e0 = exp_count;
      send(1'b1, 1'b1, 8'($urandom));
      for (int i = 0; i < 600; i++) begin
         vld = ($urandom_range(0, 3) != 0);
         sof = vld && ($urandom_range(0, 39) == 0);
         send(sof, vld, 8'($urandom));
      end
      end_phase("random", o0, e0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
